// File: rtl/store_unit_pkg.sv
// Shared constants and store-formatting helpers for the store buffer unit.
// Helpers work on a 64-bit datapath; callers truncate to XLEN.
package store_unit_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  mask;
    } fmt_t;

    // Only the low 'size' bytes of rs2 are kept, then moved to byte lane 'off'.
    function automatic fmt_t fmt_store(input logic [1:0] size, input logic [2:0] off,
                                       input logic [63:0] rs2);
        fmt_t        f;
        logic [63:0] d;
        logic [7:0]  m;
        case (size)
            SZ_B:    begin d = {56'h0, rs2[7:0]};  m = 8'h01; end
            SZ_H:    begin d = {48'h0, rs2[15:0]}; m = 8'h03; end
            SZ_W:    begin d = {32'h0, rs2[31:0]}; m = 8'h0F; end
            default: begin d = rs2;                m = 8'hFF; end
        endcase
        f.data = d << {off, 3'b000};
        f.mask = m << off;
        return f;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            SZ_D:    return |off;
            default: return 1'b0;
        endcase
    endfunction

    // Clears the offset bits below the access size (natural alignment).
    function automatic logic [2:0] align_off(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SZ_H:    return {off[2:1], 1'b0};
            SZ_W:    return {off[2], 2'b00};
            SZ_D:    return 3'b000;
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Generic synchronous FIFO with a combinational head read port.
module sb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/store_buffer_unit.sv
// Store formatting + DEPTH-entry store buffer draining to an AHB-lite data port.
// Optional MISALIGN_TRAP_EN: flags and drops misaligned stores instead of aligning them.
module store_buffer_unit
    import store_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_n_in,
    input  logic [2:0]        funct3_in,
    input  logic [XLEN-1:0]   iadder_in,
    input  logic [XLEN-1:0]   rs2_in,
    input  logic              mem_wr_req_in,
    output logic              st_ready_out,
    input  logic              ahb_ready_in,
    output logic [XLEN-1:0]   ms_riscv32_mp_dmaddr_out,
    output logic [XLEN-1:0]   ms_riscv32_mp_dmdata_out,
    output logic [XLEN/8-1:0] ms_riscv32_mp_dmwr_mask_out,
    output logic              ms_riscv32_mp_dmwr_req_out,
    output logic [1:0]        ahb_htrans_out,
    output logic              sb_empty_out
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misaligned_out
`endif
);
    localparam int NB      = XLEN / 8;
    localparam int OFFW    = $clog2(NB);
    localparam int ENTRY_W = XLEN + XLEN + NB;

    logic [1:0]         size;
    logic [2:0]         off_raw;
    logic [2:0]         off_eff;
    logic [63:0]        rs2_ext;
    fmt_t               fmt;
    logic               misaligned;
    logic [XLEN-1:0]    addr_aligned;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               unused_bits;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        size    = funct3_in[1:0];
        if (XLEN == 32 && size == SZ_D) size = SZ_W;
        off_raw = '0;
        off_raw[OFFW-1:0] = iadder_in[OFFW-1:0];
        rs2_ext = '0;
        rs2_ext[XLEN-1:0] = rs2_in;
        off_eff    = align_off(size, off_raw);
        misaligned = mem_wr_req_in && is_misaligned(size, off_raw);
        fmt        = fmt_store(size, off_eff, rs2_ext);
    end

    assign addr_aligned = {iadder_in[XLEN-1:OFFW], OFFW'(0)};
    assign wr_entry     = {addr_aligned, fmt.data[XLEN-1:0], fmt.mask[NB-1:0]};

`ifdef MISALIGN_TRAP_EN
    assign push           = mem_wr_req_in && !full && !misaligned;
    assign misaligned_out = misaligned;
    assign unused_bits    = ^{funct3_in[2], fmt.data, fmt.mask};
`else
    // Without the trap, misaligned stores are simply realigned to the access size.
    assign push        = mem_wr_req_in && !full;
    assign unused_bits = ^{funct3_in[2], fmt.data, fmt.mask, misaligned};
`endif
    assign pop = !empty && ahb_ready_in;

    sb_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (ms_riscv32_mp_clk_in),
        .rst_n  (ms_riscv32_mp_rst_n_in),
        .push   (push),
        .pop    (pop),
        .wr_data(wr_entry),
        .head   (head),
        .full   (full),
        .empty  (empty)
    );

    // Head fields read as zero while the buffer is empty.
    assign {ms_riscv32_mp_dmaddr_out, ms_riscv32_mp_dmdata_out, ms_riscv32_mp_dmwr_mask_out} =
        empty ? '0 : head;
    assign ms_riscv32_mp_dmwr_req_out = !empty;
    assign ahb_htrans_out             = empty ? HTRANS_IDLE : HTRANS_NONSEQ;
    assign sb_empty_out               = empty;
    assign st_ready_out               = !full;

endmodule

// File: tb/tb_store_buffer_unit.sv
// Directed self-checking bench for store_buffer_unit (XLEN=32 and XLEN=64 instances).
module tb_store_buffer_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_checks = 0;
    int          n_fail   = 0;

    // XLEN=32 instance
    logic [2:0]  f3;
    logic [31:0] addr, rs2;
    logic        req, rdy;
    logic        st_ready, dm_req, empty;
    logic [31:0] dm_addr, dm_data;
    logic [3:0]  dm_mask;
    logic [1:0]  htrans;

    // XLEN=64 instance
    logic [2:0]  f3_64;
    logic [63:0] addr_64, rs2_64;
    logic        req_64, rdy_64;
    logic        st_ready_64, dm_req_64, empty_64;
    logic [63:0] dm_addr_64, dm_data_64;
    logic [7:0]  dm_mask_64;
    logic [1:0]  htrans_64;
`ifdef MISALIGN_TRAP_EN
    logic        mis, mis_64;
`endif

    always #5 clk = ~clk;

    store_buffer_unit #(.XLEN(32), .DEPTH(4)) dut (
        .ms_riscv32_mp_clk_in       (clk),
        .ms_riscv32_mp_rst_n_in     (rst_n),
        .funct3_in                  (f3),
        .iadder_in                  (addr),
        .rs2_in                     (rs2),
        .mem_wr_req_in              (req),
        .st_ready_out               (st_ready),
        .ahb_ready_in               (rdy),
        .ms_riscv32_mp_dmaddr_out   (dm_addr),
        .ms_riscv32_mp_dmdata_out   (dm_data),
        .ms_riscv32_mp_dmwr_mask_out(dm_mask),
        .ms_riscv32_mp_dmwr_req_out (dm_req),
        .ahb_htrans_out             (htrans),
        .sb_empty_out               (empty)
`ifdef MISALIGN_TRAP_EN
        ,
        .misaligned_out             (mis)
`endif
    );

    store_buffer_unit #(.XLEN(64), .DEPTH(4)) dut64 (
        .ms_riscv32_mp_clk_in       (clk),
        .ms_riscv32_mp_rst_n_in     (rst_n),
        .funct3_in                  (f3_64),
        .iadder_in                  (addr_64),
        .rs2_in                     (rs2_64),
        .mem_wr_req_in              (req_64),
        .st_ready_out               (st_ready_64),
        .ahb_ready_in               (rdy_64),
        .ms_riscv32_mp_dmaddr_out   (dm_addr_64),
        .ms_riscv32_mp_dmdata_out   (dm_data_64),
        .ms_riscv32_mp_dmwr_mask_out(dm_mask_64),
        .ms_riscv32_mp_dmwr_req_out (dm_req_64),
        .ahb_htrans_out             (htrans_64),
        .sb_empty_out               (empty_64)
`ifdef MISALIGN_TRAP_EN
        ,
        .misaligned_out             (mis_64)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        f3 = f; addr = a; rs2 = d; req = 1'b1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m);
        check({tag, "_addr"}, 64'(dm_addr), 64'(a));
        check({tag, "_data"}, 64'(dm_data), 64'(d));
        check({tag, "_mask"}, 64'(dm_mask), 64'(m));
        check({tag, "_req"},  64'(dm_req),  64'h1);
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_empty"},  64'(empty),  64'h1);
        check({tag, "_req"},    64'(dm_req), 64'h0);
        check({tag, "_htrans"}, 64'(htrans), 64'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        f3 = 3'b010; addr = '0; rs2 = '0; req = 1'b0; rdy = 1'b0;
        f3_64 = 3'b011; addr_64 = '0; rs2_64 = '0; req_64 = 1'b0; rdy_64 = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        check_empty("rst");
        check("rst_ready", 64'(st_ready), 64'h1);
        check("rst_addr",  64'(dm_addr),  64'h0);
        check("rst_data",  64'(dm_data),  64'h0);
        check("rst_mask",  64'(dm_mask),  64'h0);

        // 1: SW with bus ready -> visible next cycle, gone the cycle after
        rdy = 1'b1;
        drive(3'b010, 32'h0000_1000, 32'hDEAD_BEEF);
        step();
        req = 1'b0;
        check_head("t1", 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
        check("t1_htrans", 64'(htrans), 64'h2);
        step();
        check_empty("t1_drained");

        // 2: SB at offset 3 then SH at offset 2
        rdy = 1'b0;
        drive(3'b000, 32'h0000_2003, 32'h0000_00A5);
        step();
        check_head("t2_sb", 32'h0000_2000, 32'hA500_0000, 4'b1000);
        drive(3'b001, 32'h0000_2002, 32'h0000_1234);
        step();
        req = 1'b0;
        rdy = 1'b1;
        step();
        check_head("t2_sh", 32'h0000_2000, 32'h1234_0000, 4'b1100);
        step();
        check_empty("t2_drained");

        // 3: fill while stalled, 5th held, then drain in order
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(3'b010, 32'h100 + 32'(4 * i), 32'(i + 1));
            step();
        end
        check("t3_full_ready", 64'(st_ready), 64'h0);
        drive(3'b010, 32'h110, 32'h5);
        step();
        check("t3_held_ready", 64'(st_ready), 64'h0);
        check_head("t3_h0", 32'h100, 32'h1, 4'hF);
        rdy = 1'b1;
        step();
        check("t3_ready_at3", 64'(st_ready), 64'h1);
        check_head("t3_h1", 32'h104, 32'h2, 4'hF);
        step();
        req = 1'b0;
        check_head("t3_h2", 32'h108, 32'h3, 4'hF);
        step();
        check_head("t3_h3", 32'h10C, 32'h4, 4'hF);
        step();
        check_head("t3_h4", 32'h110, 32'h5, 4'hF);
        step();
        check_empty("t3_drained");

        // 4: steady push+pop at occupancy 2 across pointer wrap
        rdy = 1'b0;
        drive(3'b010, 32'h200, 32'hC000_0000);
        step();
        drive(3'b010, 32'h204, 32'hC000_0001);
        step();
        rdy = 1'b1;
        for (int i = 2; i < 10; i++) begin
            drive(3'b010, 32'h200 + 32'(4 * i), 32'hC000_0000 + 32'(i));
            step();
            check_head("t4_stream", 32'h200 + 32'(4 * (i - 1)), 32'hC000_0000 + 32'(i - 1), 4'hF);
            check("t4_ready", 64'(st_ready), 64'h1);
        end
        req = 1'b0;
        step();
        check_head("t4_last", 32'h224, 32'hC000_0009, 4'hF);
        step();
        check_empty("t4_drained");

        // 5: reset with three stalled entries discards them all
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(3'b010, 32'h300 + 32'(4 * i), 32'hE0 + 32'(i));
            step();
        end
        req = 1'b0;
        check_head("t5_pre", 32'h300, 32'hE0, 4'hF);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_empty("t5_rst");
        check("t5_ready", 64'(st_ready), 64'h1);
        rdy = 1'b1;
        step();
        check_empty("t5_after");

        // 6: misaligned store handling
        rdy = 1'b0;
`ifdef MISALIGN_TRAP_EN
        drive(3'b010, 32'h0000_3002, 32'h1122_3344);
        #1;
        check("t6_mis_flag", 64'(mis), 64'h1);
        check("t6_mis_ready", 64'(st_ready), 64'h1);
        step();
        req = 1'b0;
        #1;
        check("t6_mis_flag_idle", 64'(mis), 64'h0);
        check_empty("t6_not_enq");
`else
        drive(3'b010, 32'h0000_3002, 32'h1122_3344);
        step();
        req = 1'b0;
        check_head("t6_sw_align", 32'h0000_3000, 32'h1122_3344, 4'hF);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        drive(3'b001, 32'h0000_3001, 32'h0000_BEEF);
        step();
        req = 1'b0;
        check_head("t6_sh_align", 32'h0000_3000, 32'h0000_BEEF, 4'b0011);
`endif

        // XLEN=64: SD at 0x4008 and SB at lane 5
        rdy_64 = 1'b0;
        check("x64_rst_empty", 64'(empty_64), 64'h1);
        f3_64 = 3'b011; addr_64 = 64'h4008; rs2_64 = 64'h0123_4567_89AB_CDEF; req_64 = 1'b1;
        step();
        f3_64 = 3'b000; addr_64 = 64'h4005; rs2_64 = 64'h0000_0000_0000_005A;
        check("x64_sd_addr", dm_addr_64, 64'h4008);
        check("x64_sd_data", dm_data_64, 64'h0123_4567_89AB_CDEF);
        check("x64_sd_mask", 64'(dm_mask_64), 64'hFF);
        check("x64_sd_htrans", 64'(htrans_64), 64'h2);
        step();
        req_64 = 1'b0;
        rdy_64 = 1'b1;
        step();
        check("x64_sb_addr", dm_addr_64, 64'h4000);
        check("x64_sb_data", dm_data_64, 64'h0000_5A00_0000_0000);
        check("x64_sb_mask", 64'(dm_mask_64), 64'h20);
        step();
        check("x64_drained", 64'(empty_64), 64'h1);
        check("x64_ready", 64'(st_ready_64), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
